stack_arb: RTL
==============

STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 Reset is asynchronous and active-low on rstN; the block has one clock, clk, and all state updates on its rising edge.
REQ-002 clk  in  1  system clock.
REQ-003 rstN  in  1  asynchronous active-low reset.
REQ-004 req0, req1  in  1 each  request from requester 0 / 1; held high until that requester's ack.
REQ-005 op0, op1  in  1 each  1=push, 0=pop; stable while the matching req is high.
REQ-006 wdata0, wdata1  in  4 each  push data; stable while the matching req is high.
REQ-007 ack0, ack1  out  1 each  one-cycle completion pulse for the matching requester.
REQ-008 err  out  1  qualifies ack: operation rejected, stack untouched.
REQ-009 rdata  out  4  popped value, valid while ack is high for a successful pop; 0 otherwise.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 stk_push, stk_pop  out  1 each  strobes to the 8x4 stack.
REQ-012 stk_data_in  out  4  push data to the stack.
REQ-013 stk_data_out  in  4  stack output register.
REQ-014 stk_full, stk_empty  in  1 each  stack status flags.

Function
REQ-015 The FSM shall have exactly three states: IDLE, ISSUE and RESP.
REQ-016 IDLE: if any req is high at an edge, the block shall latch the winner's index, op and wdata; go to ISSUE if the op is legal, else to RESP with err set.
REQ-017 Legality is sampled at the grant edge: push is illegal when stk_full=1; pop is illegal when stk_empty=1.
REQ-018 ISSUE lasts one cycle: exactly one of stk_push/stk_pop is high; stk_data_in equals the latched wdata (pop: 0). The FSM then goes to RESP.
REQ-019 RESP lasts one cycle: ack of the latched requester is high; err per REQ-016; rdata=stk_data_out for a legal pop. The FSM then goes to IDLE.
REQ-020 Latency from the grant edge to ack: 2 cycles for a legal op, 1 cycle for a rejected op.
REQ-021 stk_push and stk_pop shall never be high together, and both shall be low outside ISSUE.
REQ-022 The arbiter shall never drive simultaneous push+pop; requesters see strictly serialized operations.
REQ-023 Throughput: one operation per 3 cycles (legal) or 2 cycles (rejected); a req still high in the IDLE cycle after its ack is a new request.
REQ-024 ack0 and ack1 shall never be high together; err=0 whenever both acks are low.
REQ-025 Arbitration policy between simultaneous requests is defined in Configuration; a lone requester is always granted.

Reset
REQ-026 While rstN=0: state=IDLE; ack0=ack1=err=busy=stk_push=stk_pop=0; rdata=stk_data_in=0; round-robin pointer favours requester 0. All of these take effect immediately, without waiting for clk.
REQ-027 A reset asserted in ISSUE or RESP shall abort the operation with no ack; the stack's own contents are not reset by this block.

Configuration
REQ-028 With STACK_ARB_RR_EN defined: round-robin; on simultaneous requests, the requester not granted last wins; the pointer updates at each grant.
REQ-029 Without STACK_ARB_RR_EN: fixed priority; requester 0 always wins simultaneous requests; no pointer state exists.

Verification
REQ-030 Reset, empty stack, req0 push 4'hA -> stk_push high one cycle, 2 cycles later ack0=1, err=0; stack then holds A.
REQ-031 After REQ-030, req1 pop -> stk_pop high one cycle, ack1=1 with rdata=4'hA, err=0.
REQ-032 Empty stack, req0 pop -> no strobe, ack0=1, err=1 one cycle after grant, rdata=0.
REQ-033 Eight legal pushes, then a ninth push with stk_full=1 -> ack with err=1; stk_push stays low.
REQ-034 req0 and req1 both held high continuously, RR_EN defined -> grants alternate 0,1,0,1; without the macro -> requester 0 is granted every time.
REQ-035 rstN pulsed low during ISSUE -> strobes drop at once, no ack; after release, state=IDLE and busy=0.

Source files
------------

// File: rtl/stack_arb.sv
// Serialising arbiter that lets two requesters push to and pop from an external 8x4 stack.
// Define STACK_ARB_RR_EN for round-robin arbitration; without it requester 0 has fixed priority.
module stack_arb (
   input  logic       clk,
   input  logic       rstN,
   input  logic       req0,
   input  logic       req1,
   input  logic       op0,
   input  logic       op1,
   input  logic [3:0] wdata0,
   input  logic [3:0] wdata1,
   output logic       ack0,
   output logic       ack1,
   output logic       err,
   output logic [3:0] rdata,
   output logic       busy,
   output logic       stk_push,
   output logic       stk_pop,
   output logic [3:0] stk_data_in,
   input  logic [3:0] stk_data_out,
   input  logic       stk_full,
   input  logic       stk_empty
);

   // state | meaning
   // IDLE  | waiting for a request; grant happens at the edge leaving IDLE
   // ISSUE | one-cycle push or pop strobe to the stack
   // RESP  | one-cycle ack (and err/rdata) to the granted requester
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic       idx_q;
   logic       op_q;
   logic       err_q;
   logic [3:0] wdata_q;

   logic       any_req;
   logic       gnt_idx;
   logic       gnt_op;
   logic [3:0] gnt_wdata;
   logic       gnt_illegal;
   logic       grant;

   assign any_req = req0 | req1;
   assign grant   = (state_q == IDLE) && any_req;

`ifdef STACK_ARB_RR_EN
   // prio_q names the requester that wins the next tie; it flips away from each winner.
   logic prio_q;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)
         prio_q <= 1'b0;
      else if (grant)
         prio_q <= ~gnt_idx;
   end

   assign gnt_idx = (req0 && req1) ? prio_q : req1;
`else
   assign gnt_idx = ~req0;
`endif

   assign gnt_op      = gnt_idx ? op1 : op0;
   assign gnt_wdata   = gnt_idx ? wdata1 : wdata0;
   assign gnt_illegal = gnt_op ? stk_full : stk_empty;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
         idx_q   <= 1'b0;
         op_q    <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= 4'd0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            idx_q   <= gnt_idx;
            op_q    <= gnt_op;
            err_q   <= gnt_illegal;
            wdata_q <= gnt_wdata;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ack0        = 1'b0;
      ack1        = 1'b0;
      err         = 1'b0;
      rdata       = 4'd0;
      busy        = 1'b0;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_data_in = 4'd0;
      case (state_q)
         IDLE: begin
            if (any_req)
               state_d = gnt_illegal ? RESP : ISSUE;
         end
         ISSUE: begin
            busy     = 1'b1;
            stk_push = op_q;
            stk_pop  = ~op_q;
            if (op_q)
               stk_data_in = wdata_q;
            state_d  = RESP;
         end
         RESP: begin
            busy = 1'b1;
            ack0 = ~idx_q;
            ack1 = idx_q;
            err  = err_q;
            if (!err_q && !op_q)
               rdata = stk_data_out;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
